// File: rtl/alu_share_arbiter_pkg.sv
// alu_share_arbiter_pkg: shared opcodes, FSM state encoding and default datapath width
package alu_share_arbiter_pkg;
   localparam int DEFAULT_WIDTH = 32;
   typedef enum logic [1:0] {OP_AND = 2'b00, OP_OR = 2'b01, OP_XOR = 2'b10, OP_NOR = 2'b11} op_e;
   // one-hot so exactly one state bit is ever set
   typedef enum logic [2:0] {IDLE = 3'b001, EXEC = 3'b010, RESP = 3'b100} state_e;
endpackage

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: two requester channels, one response channel and the done counter
//   master: drives reqN_valid/op/a/b and rsp_ready; slave: drives reqN_ready, rsp_*, done_cnt
interface alu_share_arbiter_if import alu_share_arbiter_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = 16
);
   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [1:0]       req0_op, req1_op;
   logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
   logic             rsp_valid, rsp_ready, rsp_id;
   logic [WIDTH-1:0] rsp_data;
   logic [CNT_W-1:0] done_cnt;
   modport master (
      output req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b, rsp_ready,
      input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, done_cnt
   );
   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b, rsp_ready,
      output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, done_cnt
   );
endinterface

// File: rtl/alu_share_arbiter_logic_unit_32b.sv
// logic_unit_32b: combinational bitwise op; ports op (opcode), a/b (operands) -> y (result)
module logic_unit_32b import alu_share_arbiter_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  op_e              op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);
   always_comb y = op == OP_AND ? a & b : op == OP_OR ? a | b : op == OP_XOR ? a ^ b : ~(a | b);
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one bitwise logic unit between two requesters
//   clk, rst (async, active-high); bus (slave modport): request channels 0/1, response channel, done_cnt
module alu_share_arbiter import alu_share_arbiter_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = 16
) (
   input logic              clk,
   input logic              rst,
   alu_share_arbiter_if.slave bus
);
   state_e           state;
   logic             last;
   op_e              op_q;
   logic [WIDTH-1:0] a_q, b_q, y;
   logic             gnt0, gnt1;
   // on contention the requester not granted last wins; last resets to 1 so req0 wins first
   always_comb begin
      gnt0 = !rst && state == IDLE && bus.req0_valid && (!bus.req1_valid || last);
      gnt1 = !rst && state == IDLE && bus.req1_valid && (!bus.req0_valid || !last);
   end
   assign bus.req0_ready = gnt0;
   assign bus.req1_ready = gnt1;
   logic_unit_32b #(.WIDTH(WIDTH)) u_lu (.op(op_q), .a(a_q), .b(b_q), .y(y));
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state        <= IDLE;
         last         <= 1'b1;
         op_q         <= OP_AND;
         a_q          <= '0;
         b_q          <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= '0;
         bus.rsp_id    <= 1'b0;
         bus.done_cnt  <= '0;
      end else
         case (state)
            IDLE:
               if (gnt0 || gnt1) begin
                  op_q       <= op_e'(gnt1 ? bus.req1_op : bus.req0_op);
                  a_q        <= gnt1 ? bus.req1_a : bus.req0_a;
                  b_q        <= gnt1 ? bus.req1_b : bus.req0_b;
                  bus.rsp_id <= gnt1;
                  last       <= gnt1;
                  state      <= EXEC;
               end
            EXEC: begin
               bus.rsp_data  <= y;
               bus.rsp_valid <= 1'b1;
               state         <= RESP;
            end
            RESP:
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  bus.done_cnt  <= &bus.done_cnt ? bus.done_cnt : bus.done_cnt + CNT_W'(1);
                  state         <= IDLE;
               end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed checks of arbitration, latency, backpressure, reset and counter saturation
module tb_alu_share_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] sweep_exp [4] = '{32'hAAAA_0000, 32'hFFFF_5555, 32'h5555_5555, 32'h0000_AAAA};
   logic [1:0]  sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
   always #5 clk = ~clk;
   alu_share_arbiter_if #(.WIDTH(32), .CNT_W(16)) m ();
   alu_share_arbiter_if #(.WIDTH(32), .CNT_W(2))  s ();
   alu_share_arbiter #(.WIDTH(32), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(m));
   alu_share_arbiter #(.WIDTH(32), .CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .bus(s));
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   initial begin
      {m.req0_valid, m.req1_valid, m.req0_op, m.req1_op} = '0;
      {m.req0_a, m.req0_b, m.req1_a, m.req1_b} = '0;
      {s.req0_valid, s.req1_valid, s.req0_op, s.req1_op} = '0;
      {s.req0_a, s.req0_b, s.req1_a, s.req1_b} = '0;
      m.rsp_ready = 1'b1;
      s.rsp_ready = 1'b1;
      m.req0_valid = 1'b1;
      step;
      step;
      chk("rst_rsp_valid", m.rsp_valid, 0);
      chk("rst_req0_ready", m.req0_ready, 0);
      chk("rst_req1_ready", m.req1_ready, 0);
      chk("rst_rsp_data", m.rsp_data, 0);
      chk("rst_rsp_id", m.rsp_id, 0);
      chk("rst_done_cnt", m.done_cnt, 0);
      m.req0_valid = 1'b0;
      rst = 1'b0;
      // single request, OR
      step;
      m.req0_valid = 1'b1;
      m.req0_op = 2'b01;
      m.req0_a = 32'h0000_F0F0;
      m.req0_b = 32'h0F0F_0000;
      #1;
      chk("single_req0_ready", m.req0_ready, 1);
      chk("single_req1_ready", m.req1_ready, 0);
      chk("single_idle_valid", m.rsp_valid, 0);
      step;
      m.req0_valid = 1'b0;
      m.req0_op = 2'b11;
      m.req0_a = 32'h0;
      chk("single_exec_valid", m.rsp_valid, 0);
      chk("single_exec_ready", m.req0_ready, 0);
      step;
      chk("single_resp_valid", m.rsp_valid, 1);
      chk("single_resp_data", m.rsp_data, 32'h0F0F_F0F0);
      chk("single_resp_id", m.rsp_id, 0);
      chk("single_cnt_before", m.done_cnt, 0);
      step;
      chk("single_after_valid", m.rsp_valid, 0);
      chk("single_after_cnt", m.done_cnt, 1);
      chk("single_after_data", m.rsp_data, 32'h0F0F_F0F0);
      // contention from fresh reset
      rst = 1'b1;
      step;
      rst = 1'b0;
      m.req0_valid = 1'b1;
      m.req0_op = 2'b10;
      m.req0_a = 32'h1234_5678;
      m.req0_b = 32'hFFFF_0000;
      m.req1_valid = 1'b1;
      m.req1_op = 2'b00;
      m.req1_a = 32'hFFFF_FFFF;
      m.req1_b = 32'hFFFF_FFFF;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("rr_req0_ready", m.req0_ready, (k % 2) == 0);
         chk("rr_req1_ready", m.req1_ready, (k % 2) == 1);
         step;
         chk("rr_exec_ready", m.req0_ready | m.req1_ready, 0);
         step;
         chk("rr_resp_valid", m.rsp_valid, 1);
         chk("rr_resp_id", m.rsp_id, k % 2);
         chk("rr_resp_data", m.rsp_data, (k % 2) == 1 ? 32'hFFFF_FFFF : 32'hEDCB_5678);
         chk("rr_resp_ready", m.req0_ready | m.req1_ready, 0);
         step;
         #1;
      end
      // backpressure on a req0 result
      m.rsp_ready = 1'b0;
      chk("bp_grant0", m.req0_ready, 1);
      step;
      step;
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", m.rsp_valid, 1);
         chk("bp_data", m.rsp_data, 32'hEDCB_5678);
         chk("bp_id", m.rsp_id, 0);
         chk("bp_ready", m.req0_ready | m.req1_ready, 0);
         step;
      end
      m.rsp_ready = 1'b1;
      #1;
      chk("bp_still_valid", m.rsp_valid, 1);
      step;
      #1;
      chk("bp_next_req1", m.req1_ready, 1);
      chk("bp_next_req0", m.req0_ready, 0);
      chk("bp_cnt", m.done_cnt, 5);
      m.req0_valid = 1'b0;
      m.req1_valid = 1'b0;
      #1;
      chk("drop_req1_ready", m.req1_ready, 0);
      step;
      chk("drop_no_accept", m.rsp_valid, 0);
      step;
      chk("drop_still_idle", m.rsp_valid, 0);
      // opcode sweep on req0
      m.req0_a = 32'hAAAA_5555;
      m.req0_b = 32'hFFFF_0000;
      for (int k = 0; k < 4; k++) begin
         m.req0_valid = 1'b1;
         m.req0_op = k[1:0];
         step;
         m.req0_valid = 1'b0;
         step;
         chk("sweep_data", m.rsp_data, sweep_exp[k]);
         chk("sweep_id", m.rsp_id, 0);
         step;
      end
      chk("sweep_cnt", m.done_cnt, 9);
      // async reset while EXEC, then simultaneous request must go to req0
      m.req0_valid = 1'b1;
      m.req0_op = 2'b01;
      step;
      m.req0_valid = 1'b0;
      chk("mid_exec_valid", m.rsp_valid, 0);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", m.rsp_valid, 0);
      chk("mid_rst_cnt", m.done_cnt, 0);
      chk("mid_rst_data", m.rsp_data, 0);
      chk("mid_rst_id", m.rsp_id, 0);
      step;
      rst = 1'b0;
      step;
      chk("post_rst_idle", m.rsp_valid, 0);
      m.req0_valid = 1'b1;
      m.req1_valid = 1'b1;
      #1;
      chk("post_rst_req0", m.req0_ready, 1);
      chk("post_rst_req1", m.req1_ready, 0);
      step;
      m.req0_valid = 1'b0;
      m.req1_valid = 1'b0;
      step;
      step;
      // 2-bit counter saturation
      s.req0_op = 2'b01;
      s.req0_a = 32'h1;
      s.req0_b = 32'h2;
      for (int k = 0; k < 5; k++) begin
         s.req0_valid = 1'b1;
         step;
         s.req0_valid = 1'b0;
         step;
         step;
         chk("sat_cnt", s.done_cnt, sat_exp[k]);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 Parameter: CNT_W, 16, width of completed-operation counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 has an operation pending.
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-007 req0_op  input  2  requester 0 opcode: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-008 req0_a, req0_b  input  WIDTH each  requester 0 operands.
REQ-009 req1_valid, req1_ready, req1_op, req1_a, req1_b  same directions/widths/meanings for requester 1.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer accepts result.
REQ-012 rsp_data  output  WIDTH  bitwise result.
REQ-013 rsp_id  output  1  index of requester that issued the result.
REQ-014 done_cnt  output  CNT_W  count of completed response handshakes, saturating.

Function
REQ-015 FSM states IDLE, EXEC, RESP; exactly one active at all times.
REQ-016 IDLE: if no reqN_valid, stay IDLE, both readies low.
REQ-017 IDLE with one valid: assert that requester's ready combinationally in the same cycle, latch op/a/b and id, go EXEC.
REQ-018 IDLE with both valid: grant the requester not granted last (round-robin); update last-grant pointer on grant.
REQ-019 At most one reqN_ready high in any cycle; readies low in EXEC and RESP.
REQ-020 EXEC: compute latched op bitwise over all WIDTH bits, register into rsp_data, go RESP (one cycle).
REQ-021 RESP: rsp_valid high; rsp_data, rsp_id stable until rsp_valid && rsp_ready.
REQ-022 On response handshake: go IDLE, increment done_cnt unless at all-ones (saturate, no wrap).
REQ-023 Latency: acceptance in cycle t -> rsp_valid first high in cycle t+2; with rsp_ready held high, next acceptance no earlier than t+3.
REQ-024 Requester valid dropping while not granted: no effect, no grant recorded.
REQ-025 Inputs changing after acceptance do not affect the in-flight result.
REQ-026 rsp_valid low in IDLE and EXEC; rsp_data holds last computed value outside RESP.

Reset
REQ-027 rst asserted at any time, including mid-EXEC or mid-RESP, SHALL immediately force IDLE, discard the in-flight operation, and drive rsp_valid=0, req0_ready=0, req1_ready=0, rsp_data=0, rsp_id=0, done_cnt=0.
REQ-028 Reset sets last-grant pointer to 1, so requester 0 wins the first simultaneous request.

Structure
REQ-029 Shared package holds opcode constants (OP_AND, OP_OR, OP_XOR, OP_NOR), FSM state encoding, default WIDTH.
REQ-030 Bitwise compute is a sub-module logic_unit_32b (op, a, b -> y, purely combinational); arbiter owns all registers.

Verification
REQ-031 Single request: req0 op=01 a=0x0000_F0F0 b=0x0F0F_0000, rsp_ready=1 -> req0_ready at t, rsp_valid at t+2, rsp_data=0x0F0F_F0F0, rsp_id=0, done_cnt=1.
REQ-032 Contention: both valid continuously after reset, req1 op=00 a=b=0xFFFF_FFFF -> grants alternate 0,1,0,1; req1 results 0xFFFF_FFFF, rsp_id alternates.
REQ-033 Backpressure: rsp_ready low 5 cycles in RESP -> rsp_valid held, rsp_data/rsp_id unchanged, both readies low, no new grant until handshake.
REQ-034 Opcode sweep: a=0xAAAA_5555 b=0xFFFF_0000 -> AND 0xAAAA_0000, OR 0xFFFF_5555, XOR 0x5555_5555, NOR 0x0000_AAAA.
REQ-035 Reset mid-operation: rst pulse during EXEC -> next cycle IDLE, rsp_valid=0, done_cnt=0; subsequent simultaneous request grants req0.
REQ-036 Saturation: CNT_W=2, run 5 operations -> done_cnt reads 1,2,3,3,3.
